bram_dump_tx: RTL and testbench
===============================

Name: bram_dump_tx

Overview:
- Reads a contiguous range of words from the shared operand BRAM and streams them out through the UART transmit interface as bytes.
- It is the reader for the BRAM image that the serial receive path writes, and is used to dump stored operands and intermediate results back to the host for debug and verification.
- An optional trailing XOR checksum byte lets the host validate each dump.

Parameters:
- ABITS, 8, BRAM address width.
- DBITS, 256, BRAM word width; must be a multiple of 8.
- BYTESLOG2, 5, log2(DBITS/8), the byte-index counter width.
- CHECKSUM_EN, 1, when 1, one XOR checksum byte follows the data bytes.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- base_addr  input  ABITS  first word address; sampled with start
- word_count  input  ABITS+1  number of words to dump; sampled with start
- rd_addr  output  ABITS  BRAM read address
- rd_data  input  DBITS  BRAM read data, valid 1 cycle after rd_addr
- is_transmitting  input  1  UART busy flag
- tx_byte  output  8  byte to transmit
- tx_valid  output  1  one-cycle transmit strobe to the UART
- busy  output  1  high from the cycle after an accepted start until the cycle before done
- done  output  1  one-cycle pulse after the final byte has completed

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-dump):
  - Outputs: rd_addr=0, tx_byte=0, tx_valid=0, busy=0, done=0.
  - Internals: state=IDLE, checksum=0, counters=0.
  - A dump in progress is abandoned; no further tx_valid is issued.
- States: IDLE, READ, LOAD, SEND, WAIT_ACK, WAIT_TX, CSUM, DONE.
- IDLE:
  - When start=1: latch base_addr into the address counter and word_count into the remaining-words counter, clear checksum, set busy.
  - If word_count=0, go to CSUM when CHECKSUM_EN=1, otherwise to DONE. Else go to READ.
  - start is ignored in every other state.
- READ: drive rd_addr = address counter; go to LOAD next cycle.
- LOAD: capture rd_data into the DBITS shift register, clear byte index, go to SEND.
- SEND:
  - Wait while is_transmitting=1.
  - When it is 0: tx_byte = shift_reg[7:0], tx_valid=1 for exactly one cycle, checksum ^= tx_byte; go to WAIT_ACK.
- WAIT_ACK:
  - Wait for is_transmitting=1.
  - Timeout: if is_transmitting is still 0 after 4 cycles, treat the byte as accepted and go to WAIT_TX. This tolerates a UART that is already done or slow to assert.
- WAIT_TX: wait for is_transmitting=0, then take the first matching case:
  - Bytes remain in the current word: shift right by 8, increment byte index, go to SEND.
  - Last byte of the word and words remain: decrement remaining, increment address (modulo 2^ABITS), go to READ.
  - Last byte of the last word: go to CSUM when CHECKSUM_EN=1, otherwise to DONE.
- CSUM: send the checksum byte with the same SEND/WAIT_ACK/WAIT_TX handshake, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Byte order: LSB byte of each word first; words in ascending address order.
- Address counter wraps: base 0xFF with count 2 reads 0xFF then 0x00.
- tx_byte holds its last value between strobes.
- Throughput: never more than one tx_valid per UART frame. No back-to-back strobes; at least 3 cycles between strobes.
- word_count is ABITS+1 bits, so a full-memory dump (2^ABITS words) is allowed.

Test Plan:
- Reset, then start with base=3, count=1; word at 3 = 0x00..0201 (bytes 01,02,…,0x20). Expected response:
  - 32 data bytes 0x01..0x20, LSB first.
  - Checksum byte = XOR of 0x01..0x20 = 0x20.
  - done pulses once; 33 tx_valid strobes in total.
- start with count=0, CHECKSUM_EN=1 -> exactly one byte 0x00 sent, then done. With CHECKSUM_EN=0 -> no tx_valid; done pulses 2 cycles after start.
- Wrap: base=0xFF, count=2 -> rd_addr sequence 0xFF then 0x00; 64 data bytes in that order.
- UART model holds is_transmitting high for 100 cycles per byte -> no tx_valid while high; each strobe occurs ≥1 cycle after is_transmitting falls.
- UART model never raises is_transmitting -> WAIT_ACK timeout after 4 cycles; dump completes with all bytes strobed.
- Assert rst during byte 10 of a dump -> from the next cycle busy=0, tx_valid=0, state IDLE. A new start, base=0 and count=1, then produces a clean 33-byte dump with a fresh checksum.

Source files
------------

// File: rtl/bram_dump_tx.sv
// Streams a contiguous range of BRAM words to the UART transmitter, LSB byte first,
// optionally followed by an XOR checksum byte of everything sent.
module bram_dump_tx #(
  parameter int ABITS       = 8,
  parameter int DBITS       = 256,
  parameter int BYTESLOG2   = 5,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS:0]   word_count,
  output logic [ABITS-1:0] rd_addr,
  input  logic [DBITS-1:0] rd_data,
  input  logic             is_transmitting,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE, READ, LOAD, SEND, WAIT_ACK, WAIT_TX, CSUM, DONE
  } state_t;

  localparam logic [BYTESLOG2-1:0] LAST_BYTE = BYTESLOG2'(DBITS / 8 - 1);
  localparam logic [ABITS:0]       ONE_WORD  = (ABITS + 1)'(1);

  state_t               state_q, state_d;
  logic [ABITS-1:0]     addr_q, addr_d;
  logic [ABITS:0]       remain_q, remain_d;
  logic [DBITS-1:0]     shift_q, shift_d;
  logic [BYTESLOG2-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]           csum_q, csum_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           ack_cnt_q, ack_cnt_d;
  logic                 csum_phase_q, csum_phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      tx_byte_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ack_cnt_q    <= '0;
      csum_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ack_cnt_q    <= ack_cnt_d;
      csum_phase_q <= csum_phase_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ack_cnt_d    = ack_cnt_q;
    csum_phase_d = csum_phase_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          remain_d     = word_count;
          csum_d       = '0;
          busy_d       = 1'b1;
          csum_phase_d = 1'b0;
          if (word_count == '0) state_d = CHECKSUM_EN ? CSUM : DONE;
          else                  state_d = READ;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        shift_d    = rd_data;
        byte_idx_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (!is_transmitting) begin
          tx_byte_d  = shift_q[7:0];
          tx_valid_d = 1'b1;
          csum_d     = csum_q ^ shift_q[7:0];
          ack_cnt_d  = '0;
          state_d    = WAIT_ACK;
        end
      end
      // A UART that never raises its busy flag is assumed to have taken the byte.
      WAIT_ACK: begin
        if (is_transmitting || ack_cnt_q == 2'd3) state_d = WAIT_TX;
        else                                      ack_cnt_d = ack_cnt_q + 2'd1;
      end
      WAIT_TX: begin
        if (!is_transmitting) begin
          if (csum_phase_q) begin
            state_d = DONE;
          end else if (byte_idx_q != LAST_BYTE) begin
            shift_d    = shift_q >> 8;
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = SEND;
          end else if (remain_q > ONE_WORD) begin
            remain_d = remain_q - 1'b1;
            addr_d   = addr_q + 1'b1;
            state_d  = READ;
          end else begin
            state_d = CHECKSUM_EN ? CSUM : DONE;
          end
        end
      end
      CSUM: begin
        if (!is_transmitting) begin
          tx_byte_d    = csum_q;
          tx_valid_d   = 1'b1;
          csum_phase_d = 1'b1;
          ack_cnt_d    = '0;
          state_d      = WAIT_ACK;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr   = addr_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bram_dump_tx.sv
// Directed bench for bram_dump_tx: BRAM and UART models, byte monitor, expected-byte queue.
// Handshake: a byte is offered by a one-cycle tx_valid only while is_transmitting is low.
module tb_bram_dump_tx;
  localparam int ABITS = 8;
  localparam int DBITS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // checksum-enabled instance
  logic             start = 1'b0;
  logic [ABITS-1:0] base_addr = '0;
  logic [ABITS:0]   word_count = '0;
  logic [ABITS-1:0] rd_addr;
  logic [DBITS-1:0] rd_data;
  logic             is_tx;
  logic [7:0]       tx_byte;
  logic             tx_valid, busy, done;
  logic [2:0]       state_dbg;

  // checksum-disabled instance
  logic             start_nc = 1'b0;
  logic [ABITS-1:0] base_addr_nc = '0;
  logic [ABITS:0]   word_count_nc = '0;
  logic [ABITS-1:0] rd_addr_nc;
  logic [DBITS-1:0] rd_data_nc;
  logic             is_tx_nc;
  logic [7:0]       tx_byte_nc;
  logic             tx_valid_nc, busy_nc, done_nc;
  logic [2:0]       state_dbg_nc;

  bram_dump_tx #(.ABITS(ABITS), .DBITS(DBITS), .BYTESLOG2(5), .CHECKSUM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .is_transmitting(is_tx), .tx_byte(tx_byte),
    .tx_valid(tx_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  bram_dump_tx #(.ABITS(ABITS), .DBITS(DBITS), .BYTESLOG2(5), .CHECKSUM_EN(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .start(start_nc), .base_addr(base_addr_nc), .word_count(word_count_nc),
    .rd_addr(rd_addr_nc), .rd_data(rd_data_nc), .is_transmitting(is_tx_nc), .tx_byte(tx_byte_nc),
    .tx_valid(tx_valid_nc), .busy(busy_nc), .done(done_nc), .state_dbg(state_dbg_nc)
  );

  // BRAM model: one-cycle read latency
  logic [DBITS-1:0] mem [0:255];
  always @(posedge clk) begin
    rd_data    <= mem[rd_addr];
    rd_data_nc <= mem[rd_addr_nc];
  end

  // UART models: busy for `hold` cycles after each strobe, or never busy
  int hold = 4;
  bit never_ack = 1'b0;
  int ucnt = 0;
  int ucnt_nc = 0;
  always @(posedge clk) begin
    if (rst) begin
      is_tx <= 1'b0; ucnt <= 0;
    end else if (tx_valid && !never_ack) begin
      is_tx <= 1'b1; ucnt <= hold;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else begin
      ucnt <= 0; is_tx <= 1'b0;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      is_tx_nc <= 1'b0; ucnt_nc <= 0;
    end else if (tx_valid_nc) begin
      is_tx_nc <= 1'b1; ucnt_nc <= 3;
    end else if (ucnt_nc > 1) begin
      ucnt_nc <= ucnt_nc - 1;
    end else begin
      ucnt_nc <= 0; is_tx_nc <= 1'b0;
    end
  end

  // monitors, sampled on the falling edge
  logic [7:0]       got_q[$];
  logic [7:0]       got_nc_q[$];
  logic [ABITS-1:0] rd_q[$];
  logic [7:0]       exp_q[$];
  int done_cnt = 0, nc_done_cnt = 0;
  int viol_busy = 0, viol_fall = 0, viol_hold = 0;
  int last_strobe = -1, min_gap = 1000000, max_gap = 0;
  bit prev_is_tx = 1'b0;
  logic [7:0] last_tx = 8'h00;

  always @(negedge clk) begin
    if (tx_valid) begin
      got_q.push_back(tx_byte);
      if (is_tx) viol_busy++;
      if (prev_is_tx) viol_fall++;
      if (last_strobe >= 0) begin
        if (int'(cyc) - last_strobe < min_gap) min_gap = int'(cyc) - last_strobe;
        if (int'(cyc) - last_strobe > max_gap) max_gap = int'(cyc) - last_strobe;
      end
      last_strobe = int'(cyc);
      last_tx = tx_byte;
    end else if (tx_byte !== last_tx) begin
      viol_hold++;
    end
    if (rst) last_tx = 8'h00;
    if (done) done_cnt++;
    if (state_dbg == 3'd1) rd_q.push_back(rd_addr);
    prev_is_tx = is_tx;
    if (tx_valid_nc) got_nc_q.push_back(tx_byte_nc);
    if (done_nc) nc_done_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    return 32'hDEAD;
  endfunction

  task automatic clear_mon();
    got_q.delete(); rd_q.delete();
    done_cnt = 0; viol_busy = 0; viol_fall = 0; viol_hold = 0;
    last_strobe = -1; min_gap = 1000000; max_gap = 0;
  endtask

  task automatic start_dump(input logic [ABITS-1:0] b, input logic [ABITS:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); k++;
    end
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic build_exp(input logic [ABITS-1:0] b, input int n, input bit with_csum);
    logic [7:0] cs = 8'h00;
    logic [ABITS-1:0] a;
    exp_q.delete();
    for (int w = 0; w < n; w++) begin
      a = b + ABITS'(w);
      for (int i = 0; i < DBITS / 8; i++) begin
        exp_q.push_back(mem[a][8*i +: 8]);
        cs ^= mem[a][8*i +: 8];
      end
    end
    if (with_csum) exp_q.push_back(cs);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), byte_at(i), 32'(exp_q[i]));
    check({tag, "_strobe_while_busy"}, 32'(viol_busy), 32'd0);
    check({tag, "_strobe_before_fall"}, 32'(viol_fall), 32'd0);
    check({tag, "_tx_byte_hold"}, 32'(viol_hold), 32'd0);
  endtask

  initial begin
    int k;
    int n_at;
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < DBITS / 8; i++)
        mem[a][8*i +: 8] = 8'(a + i);
    for (int i = 0; i < DBITS / 8; i++) mem[3][8*i +: 8] = 8'(i + 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // one word at address 3, with a stray start mid-dump that must be ignored
    clear_mon();
    start_dump(8'd3, 9'd1);
    k = 0;
    while (got_q.size() < 5 && k < 500) begin @(posedge clk); k++; end
    #1; start = 1'b1; base_addr = 8'h80; word_count = 9'd5;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t1", 3000);
    build_exp(8'd3, 1, 1'b1);
    compare_bytes("t1");
    check("t1_first", byte_at(0), 32'h01);
    check("t1_last_data", byte_at(31), 32'h20);
    check("t1_csum", byte_at(32), 32'h20);
    check("t1_min_gap_ge3", 32'(min_gap >= 3), 32'd1);

    // zero words with checksum: a single 0x00 byte
    clear_mon();
    start_dump(8'h10, 9'd0);
    wait_done("zero", 500);
    check("zero_nbytes", 32'(got_q.size()), 32'd1);
    check("zero_csum", byte_at(0), 32'h00);

    // zero words without checksum: no strobe, done two cycles after start
    @(posedge clk); #1;
    start_nc = 1'b1; base_addr_nc = 8'h00; word_count_nc = 9'd0;
    @(posedge clk); #1;
    start_nc = 1'b0;
    @(negedge clk);
    check("nc_zero_busy", 32'(busy_nc), 32'd1);
    check("nc_zero_done_early", 32'(done_nc), 32'd0);
    @(negedge clk);
    check("nc_zero_done", 32'(done_nc), 32'd1);
    check("nc_zero_busy_at_done", 32'(busy_nc), 32'd0);
    @(negedge clk);
    check("nc_zero_done_pulse", 32'(done_nc), 32'd0);
    check("nc_zero_strobes", 32'(got_nc_q.size()), 32'd0);

    // one word without checksum: 32 bytes only
    nc_done_cnt = 0;
    @(posedge clk); #1;
    start_nc = 1'b1; base_addr_nc = 8'd3; word_count_nc = 9'd1;
    @(posedge clk); #1;
    start_nc = 1'b0;
    k = 0;
    while (nc_done_cnt == 0 && k < 2000) begin @(posedge clk); k++; end
    repeat (5) @(posedge clk);
    check("nc_one_done", 32'(nc_done_cnt), 32'd1);
    check("nc_one_nbytes", 32'(got_nc_q.size()), 32'd32);
    check("nc_one_last", (got_nc_q.size() == 32) ? 32'(got_nc_q[31]) : 32'hDEAD, 32'h20);

    // address wrap: 0xFF then 0x00
    clear_mon();
    start_dump(8'hFF, 9'd2);
    wait_done("wrap", 5000);
    build_exp(8'hFF, 2, 1'b1);
    compare_bytes("wrap");
    check("wrap_nreads", 32'(rd_q.size()), 32'd2);
    check("wrap_rd0", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hDEAD, 32'hFF);
    check("wrap_rd1", (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hDEAD, 32'h00);
    check("wrap_first", byte_at(0), 32'hFF);
    check("wrap_word1_first", byte_at(32), 32'h00);
    check("wrap_last_data", byte_at(63), 32'h1F);
    check("wrap_csum", byte_at(64), 32'hE0);

    // slow UART: busy 100 cycles per byte
    hold = 100;
    clear_mon();
    start_dump(8'd5, 9'd1);
    wait_done("slow", 10000);
    build_exp(8'd5, 1, 1'b1);
    compare_bytes("slow");
    check("slow_csum", byte_at(32), 32'h20);
    check("slow_gap_gt100", 32'(min_gap > 100), 32'd1);
    hold = 4;

    // UART that never acknowledges: four-cycle timeout per byte
    never_ack = 1'b1;
    clear_mon();
    start_dump(8'h40, 9'd1);
    wait_done("noack", 2000);
    build_exp(8'h40, 1, 1'b1);
    compare_bytes("noack");
    check("noack_csum", byte_at(32), 32'h00);
    check("noack_min_gap", 32'(min_gap), 32'd6);
    check("noack_max_gap", 32'(max_gap), 32'd6);
    never_ack = 1'b0;

    // reset during byte 10, then a clean dump
    clear_mon();
    start_dump(8'd3, 9'd1);
    k = 0;
    while (got_q.size() < 10 && k < 1000) begin @(posedge clk); k++; end
    check("abort_reached_byte10", 32'(got_q.size() >= 10), 32'd1);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    n_at = got_q.size();
    repeat (50) @(posedge clk);
    check("abort_no_more_strobes", 32'(got_q.size()), 32'(n_at));
    check("abort_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    start_dump(8'd0, 9'd1);
    wait_done("post", 3000);
    build_exp(8'd0, 1, 1'b1);
    compare_bytes("post");
    check("post_first", byte_at(0), 32'h00);
    check("post_csum", byte_at(32), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
